// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter
// Two-port round-robin bus arbiter in front of a small shared register-file
// memory. Each core presents request / write-enable / address / write-data.
// The arbiter grants at most one core at a time, and performs that core's
// read (read-before-write) and optional write every granted cycle.
//
// Optional feature: define SHARED_BUS_TIMEOUT_EN to limit a grantee to
// MAX_HOLD consecutive cycles while the other core is requesting.
//
// Ports:
//   clk                  - single clock, posedge
//   reset_in             - synchronous active-high reset
//   req0_in / req1_in    - bus requests
//   we0_in / we1_in      - write enables (only honoured for the grantee)
//   addr0_in / addr1_in  - word addresses
//   wdata0_in/wdata1_in  - write data
//   grant0_out/grant1_out- mutually exclusive grants
//   data_out             - read data from the previous granted cycle
//   data_valid_out       - data_out was produced by a read last cycle
//   owner_out            - index of the last/current grantee
module shared_bus_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  req0_in,
  input  logic                  req1_in,
  input  logic                  we0_in,
  input  logic                  we1_in,
  input  logic [ADDR_WIDTH-1:0] addr0_in,
  input  logic [ADDR_WIDTH-1:0] addr1_in,
  input  logic [DATA_WIDTH-1:0] wdata0_in,
  input  logic [DATA_WIDTH-1:0] wdata1_in,
  output logic                  grant0_out,
  output logic                  grant1_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  owner_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  grant0_q, grant1_q;
  logic                  owner_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Forced handover condition: only meaningful together with the other request.
  logic timeout_fire;

`ifdef SHARED_BUS_TIMEOUT_EN
  logic [3:0] hold_q;
  assign timeout_fire = (hold_q == 4'(MAX_HOLD - 1));
`else
  assign timeout_fire = 1'b0;
`endif

  // Signals of whichever core currently owns the bus.
  logic                  granted;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign granted   = (state_q != IDLE);
  assign sel_we    = (state_q == GRANT1) ? we1_in    : we0_in;
  assign sel_addr  = (state_q == GRANT1) ? addr1_in  : addr0_in;
  assign sel_wdata = (state_q == GRANT1) ? wdata1_in : wdata0_in;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // Contended: grant whichever core did not own the bus last.
        if (req0_in && req1_in) state_d = owner_q ? GRANT0 : GRANT1;
        else if (req0_in)       state_d = GRANT0;
        else if (req1_in)       state_d = GRANT1;
      end
      GRANT0: begin
        if (req0_in && !(timeout_fire && req1_in)) state_d = GRANT0;
        else if (req1_in)                          state_d = GRANT1;
        else                                       state_d = IDLE;
      end
      GRANT1: begin
        if (req1_in && !(timeout_fire && req0_in)) state_d = GRANT1;
        else if (req0_in)                          state_d = GRANT0;
        else                                       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q  <= IDLE;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      owner_q  <= 1'b1;  // core 0 wins the first contended arbitration
      data_q   <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      grant0_q <= (state_d == GRANT0);
      grant1_q <= (state_d == GRANT1);
      if (state_d != IDLE) owner_q <= (state_d == GRANT1);
      // Read samples the array before this edge's write lands: old value.
      if (granted) data_q <= mem_q[sel_addr];
      valid_q <= granted;
      if (granted && sel_we) mem_q[sel_addr] <= sel_wdata;
    end
  end

`ifdef SHARED_BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset_in) begin
      hold_q <= 4'd0;
    end else if (state_d != IDLE && state_d != state_q) begin
      hold_q <= 4'd0;  // fresh grant (from IDLE or handover)
    end else if (granted && hold_q != 4'(MAX_HOLD)) begin
      hold_q <= hold_q + 4'd1;
    end
  end
`endif

  assign grant0_out     = grant0_q;
  assign grant1_out     = grant1_q;
  assign data_out       = data_q;
  assign data_valid_out = valid_q;
  assign owner_out      = owner_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
module tb_shared_bus_arbiter;
  localparam int MAX_HOLD = 4;
`ifdef SHARED_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0] a0 = '0, a1 = '0;
  logic [7:0] wd0 = '0, wd1 = '0;
  logic       g0, g1, dv, own;
  logic [7:0] dout;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: grantee index (-1 = nobody), memory array, counters.
  int         m_grantee;
  logic       m_owner;
  logic [7:0] m_dout;
  logic       m_dv;
  logic [7:0] m_mem [16];
  int         m_hold;

  shared_bus_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_in(reset_in),
    .req0_in(req0), .req1_in(req1), .we0_in(we0), .we1_in(we1),
    .addr0_in(a0), .addr1_in(a1), .wdata0_in(wd0), .wdata1_in(wd1),
    .grant0_out(g0), .grant1_out(g1), .data_out(dout),
    .data_valid_out(dv), .owner_out(own)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Apply the arbitration and memory rules for one clock edge.
  task automatic model_edge();
    int  nxt;
    bit  r [2];
    bit  w;
    logic [3:0] a;
    logic [7:0] d;
    r[0] = req0; r[1] = req1;
    if (reset_in) begin
      m_grantee = -1; m_owner = 1'b1; m_dout = 8'h00; m_dv = 1'b0; m_hold = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      return;
    end
    if (m_grantee >= 0) begin
      w = (m_grantee == 1) ? we1 : we0;
      a = (m_grantee == 1) ? a1 : a0;
      d = (m_grantee == 1) ? wd1 : wd0;
      m_dout = m_mem[a];
      m_dv = 1'b1;
      if (w) m_mem[a] = d;
    end else begin
      m_dv = 1'b0;
    end
    if (m_grantee < 0) begin
      if (r[0] && r[1]) nxt = m_owner ? 0 : 1;
      else if (r[0])    nxt = 0;
      else if (r[1])    nxt = 1;
      else              nxt = -1;
    end else begin
      bit forced;
      forced = TO_EN && (m_hold == MAX_HOLD - 1) && r[1 - m_grantee];
      if (r[m_grantee] && !forced) nxt = m_grantee;
      else if (r[1 - m_grantee])   nxt = 1 - m_grantee;
      else                         nxt = -1;
    end
    if (nxt >= 0 && nxt != m_grantee) m_hold = 0;
    else if (nxt >= 0 && m_hold < MAX_HOLD) m_hold = m_hold + 1;
    if (nxt >= 0) m_owner = (nxt == 1);
    m_grantee = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; a0 = 0; a1 = 0; wd0 = 0; wd1 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_in = 1; step(); step(); reset_in = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({g0, g1, dv, dout, own} !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: g0=%b g1=%b dv=%b dout=%h own=%b, required 0 0 0 00 1", g0, g1, dv, dout, own);
    end
  endtask

  task automatic test_idle_req();
    step();
    req0 = 1; step();
    tests_run++;
    if (g0 !== 1'b1 || g1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL grant_latency: g0=%b g1=%b, required 1 0", g0, g1);
    end
  endtask

  task automatic test_write_read();
    we0 = 1; a0 = 4'h5; wd0 = 8'h55; step();
    tests_run++;
    if (dout !== 8'h00 || dv !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_old_value: dout=%h dv=%b, required 00 1", dout, dv);
    end
    we0 = 0; step();
    tests_run++;
    if (dout !== 8'h55 || dv !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_after_write: dout=%h dv=%b, required 55 1", dout, dv);
    end
    req0 = 0; step(); step();
    tests_run++;
    if (g0 !== 1'b0 || dv !== 1'b0 || dout !== 8'h55) begin
      tests_failed++;
      $display("FAIL release_idle: g0=%b dv=%b dout=%h, required 0 0 55", g0, dv, dout);
    end
  endtask

  task automatic test_isolation();
    req0 = 1; a0 = 4'h5; step();
    we1 = 1; a1 = 4'h5; wd1 = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (dout !== 8'h55 || g1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL isolation_%0d: dout=%h g1=%b, required 55 0", k, dout, g1);
      end
    end
    idle_inputs(); step(); step();
  endtask

  task automatic test_contention();
    do_reset();
    req0 = 1; req1 = 1; step();
    tests_run++;
    if (g0 !== 1'b1 || g1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL contention_first: g0=%b g1=%b, required 1 0", g0, g1);
    end
    req0 = 0; step();
    tests_run++;
    if (g0 !== 1'b0 || g1 !== 1'b1 || own !== 1'b1) begin
      tests_failed++;
      $display("FAIL handover: g0=%b g1=%b own=%b, required 0 1 1", g0, g1, own);
    end
    req1 = 0; step();
    tests_run++;
    if (g0 !== 1'b0 || g1 !== 1'b0 || own !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_owner_hold: g0=%b g1=%b own=%b, required 0 0 1", g0, g1, own);
    end
    step();
    req0 = 1; req1 = 1; step();
    tests_run++;
    if (g0 !== 1'b1 || g1 !== 1'b0 || own !== 1'b0) begin
      tests_failed++;
      $display("FAIL round_robin: g0=%b g1=%b own=%b, required 1 0 0", g0, g1, own);
    end
    idle_inputs(); step(); step();
  endtask

  task automatic test_hold();
    logic e0;
    do_reset();
    req0 = 1; req1 = 1;
    step();
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      e0 = TO_EN ? (((k / MAX_HOLD) % 2) == 0) : 1'b1;
      tests_run++;
      if (g0 !== e0 || g1 !== ~e0) begin
        tests_failed++;
        $display("FAIL hold_cycle_%0d: g0=%b g1=%b, required %b %b", k, g0, g1, e0, ~e0);
      end
    end
    idle_inputs(); step(); step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req1 = 1; step();
    we1 = 1; a1 = 4'h5; wd1 = 8'h5A; step();
    wd1 = 8'h77; reset_in = 1; step();
    reset_in = 0; idle_inputs();
    tests_run++;
    if (g0 !== 1'b0 || g1 !== 1'b0 || dv !== 1'b0 || dout !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_grant: g0=%b g1=%b dv=%b dout=%h, required 0 0 0 00", g0, g1, dv, dout);
    end
    req0 = 1; a0 = 4'h5; step(); step();
    tests_run++;
    if (dout !== 8'h00 || dv !== 1'b1) begin
      tests_failed++;
      $display("FAIL mem_cleared: dout=%h dv=%b, required 00 1", dout, dv);
    end
    idle_inputs(); step();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      // Sticky requests so grants last a few cycles and contention arises.
      if ($urandom_range(0, 3) == 0) req0 = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) req1 = $urandom_range(0, 1);
      we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
      a0 = 4'($urandom_range(0, 15)); a1 = 4'($urandom_range(0, 15));
      wd0 = 8'($urandom); wd1 = 8'($urandom);
      reset_in = ($urandom_range(0, 99) == 0);
      step();
      tests_run++;
      if (g0 !== (m_grantee == 0) || g1 !== (m_grantee == 1) || dv !== m_dv ||
          dout !== m_dout || own !== m_owner) begin
        tests_failed++;
        $display("FAIL random_%0d: g0=%b g1=%b dv=%b dout=%h own=%b, required %b %b %b %h %b",
                 k, g0, g1, dv, dout, own, (m_grantee == 0), (m_grantee == 1), m_dv, m_dout, m_owner);
      end
    end
    reset_in = 0; idle_inputs(); step();
  endtask

  initial begin
    m_grantee = -1; m_owner = 1'b1; m_dout = '0; m_dv = 1'b0; m_hold = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    test_reset();
    test_idle_req();
    test_write_read();
    test_isolation();
    test_contention();
    test_hold();
    test_reset_mid_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
